fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode stage. Holds the program counter, issues word requests to instruction memory over a request/valid handshake, and buffers returned instructions in a small FIFO. Presents `instr`, `pc_seq` (PC+4) and `pc_seq_2` (PC+8) to decode. Accepts a redirect (jump/branch target) that flushes the queue and discards any in-flight response.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding memory request, and a small
// {pc, instr} queue feeding decode. Redirect flushes and drops any stale reply.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic        imem_valid_in,
    input  logic [31:0] imem_data_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_seq_out,
    output logic [31:0] pc_seq_2_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // REQ: may issue a fetch | WAIT: reply will be queued | DROP: reply will be discarded
    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_tag;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic          w_empty;
    logic          w_req;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redirect_pc;

    always_comb begin
        w_empty       = (r_count == '0);
        w_req         = !reset && (r_state == ST_REQ) && (r_count < FULL_CNT);
        w_accept      = w_req && imem_ready_in;
        w_push        = (r_state == ST_WAIT) && imem_valid_in && !redirect_in;
        w_pop         = !w_empty && !stall_in && !redirect_in;
        w_redirect_pc = redirect_pc_in & 32'hFFFF_FFFC;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_in) begin
            // A request still in flight after this cycle must have its reply dropped.
            if ((r_state == ST_REQ && w_accept) || (r_state != ST_REQ && !imem_valid_in))
                w_state_nxt = ST_DROP;
            else
                w_state_nxt = ST_REQ;
        end else begin
            case (r_state)
                ST_REQ:  if (w_accept)      w_state_nxt = ST_WAIT;
                ST_WAIT: if (imem_valid_in) w_state_nxt = ST_REQ;
                ST_DROP: if (imem_valid_in) w_state_nxt = ST_REQ;
                default:                    w_state_nxt = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_REQ;
            r_fetch_pc <= RESET_PC;
            r_tag      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_in) begin
                r_fetch_pc <= w_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_tag      <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_tag;
            r_q_instr[r_wr_ptr] <= imem_data_in;
        end
    end

    always_comb begin
        imem_req_out  = w_req;
        imem_addr_out = r_fetch_pc;
        valid_out     = !w_empty;
        instr_out     = w_empty ? 32'h0 : r_q_instr[r_rd_ptr];
        pc_seq_out    = w_empty ? 32'h0 : r_q_pc[r_rd_ptr] + 32'd4;
        pc_seq_2_out  = w_empty ? 32'h0 : r_q_pc[r_rd_ptr] + 32'd8;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of the fetch stage.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_valid_in;
    logic [31:0] imem_data_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        stall_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_seq_out;
    logic [31:0] pc_seq_2_out;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ready_in(imem_ready_in), .imem_valid_in(imem_valid_in),
        .imem_data_in(imem_data_in), .redirect_in(redirect_in),
        .redirect_pc_in(redirect_pc_in), .stall_in(stall_in),
        .valid_out(valid_out), .instr_out(instr_out),
        .pc_seq_out(pc_seq_out), .pc_seq_2_out(pc_seq_2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // reference model: fetch address, outstanding/stale flags, entry queue
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_tag;
    bit          m_out;
    bit          m_stale;
    bit          m_known = 0;

    // memory model
    bit          mem_busy = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    int          lat_min  = 1;
    int          lat_max  = 1;

    // stimulus for the coming cycle
    bit          drv_reset = 1;
    bit          drv_ready = 1;
    bit          drv_stall = 0;
    bit          drv_redir = 0;
    logic [31:0] drv_rpc   = '0;
    bit          drv_spur  = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive();
        @(negedge clk);
        reset          = drv_reset;
        imem_ready_in  = drv_ready;
        stall_in       = drv_stall;
        redirect_in    = drv_redir;
        redirect_pc_in = drv_rpc;
        imem_valid_in  = 1'b0;
        imem_data_in   = $urandom;
        if (drv_reset) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_valid_in = 1'b1;
                imem_data_in  = mem_data(mem_addr);
                mem_busy      = 0;
            end else begin
                mem_cnt--;
            end
        end else if (drv_spur) begin
            imem_valid_in = 1'b1;
        end
        #1;
    endtask

    task automatic finish();
        bit   e_req;
        bit   acc;
        ent_t e;
        e_req = !drv_reset && !m_out && (mq.size() < DEPTH);
        if (m_known) begin
            if (mq.size() != 0) begin
                chk("valid_out", valid_out, 1);
                chk("instr_out", instr_out, mq[0].instr);
                chk("pc_seq_out", pc_seq_out, mq[0].pc + 32'd4);
                chk("pc_seq_2_out", pc_seq_2_out, mq[0].pc + 32'd8);
            end else begin
                chk("valid_out", valid_out, 0);
                chk("instr_out", instr_out, 0);
                chk("pc_seq_out", pc_seq_out, 0);
                chk("pc_seq_2_out", pc_seq_2_out, 0);
            end
            chk("imem_req_out", imem_req_out, e_req);
            if (e_req) chk("imem_addr_out", imem_addr_out, m_pc);
        end
        if (!drv_reset && imem_req_out === 1'b1 && drv_ready) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
            mem_addr = imem_addr_out;
        end
        acc = e_req && drv_ready;
        if (drv_reset) begin
            mq.delete();
            m_pc    = RESET_PC;
            m_out   = 0;
            m_stale = 0;
            m_known = 1;
        end else if (drv_redir) begin
            mq.delete();
            m_pc = drv_rpc & 32'hFFFF_FFFC;
            if (acc) begin
                m_out   = 1;
                m_stale = 1;
            end else if (m_out && imem_valid_in) begin
                m_out   = 0;
                m_stale = 0;
            end else if (m_out) begin
                m_stale = 1;
            end
        end else begin
            if (mq.size() != 0 && !drv_stall) mq.delete(0);
            if (m_out && imem_valid_in) begin
                if (!m_stale) begin
                    e.pc    = m_tag;
                    e.instr = imem_data_in;
                    mq.push_back(e);
                end
                m_out   = 0;
                m_stale = 0;
            end
            if (acc) begin
                m_tag   = m_pc;
                m_pc    = m_pc + 32'd4;
                m_out   = 1;
                m_stale = 0;
            end
        end
    endtask

    task automatic cycle();
        drive();
        finish();
    endtask

    task automatic do_reset(input int n);
        drv_reset = 1;
        drv_redir = 0;
        drv_spur  = 0;
        drv_stall = 0;
        drv_ready = 1;
        for (int i = 0; i < n; i++) begin
            drive();
            chk("rst_req", imem_req_out, 0);
            finish();
        end
        drv_reset = 0;
    endtask

    initial begin
        bit seen;
        reset = 1; imem_ready_in = 0; imem_valid_in = 0; imem_data_in = 0;
        redirect_in = 0; redirect_pc_in = 0; stall_in = 0;

        // sequential fetch with 1-cycle memory
        do_reset(3);
        drive();
        chk("t1_c0_req", imem_req_out, 1);
        chk("t1_c0_addr", imem_addr_out, 32'h0);
        chk("t1_c0_valid", valid_out, 0);
        chk("t1_c0_instr", instr_out, 0);
        chk("t1_c0_seq", pc_seq_out, 0);
        finish();
        drive(); chk("t1_c1_req", imem_req_out, 0); finish();
        drive();
        chk("t1_c2_valid", valid_out, 1);
        chk("t1_c2_instr", instr_out, mem_data(32'h0));
        chk("t1_c2_seq", pc_seq_out, 32'h4);
        chk("t1_c2_seq2", pc_seq_2_out, 32'h8);
        chk("t1_c2_addr", imem_addr_out, 32'h4);
        finish();
        cycle();
        drive();
        chk("t1_c4_req", imem_req_out, 1);
        chk("t1_c4_addr", imem_addr_out, 32'h8);
        chk("t1_c4_seq", pc_seq_out, 32'h8);
        finish();

        // stall fills the queue, then drains in order
        do_reset(2);
        drv_stall = 1;
        repeat (4) cycle();
        for (int i = 0; i < 3; i++) begin
            drive();
            chk("t2_hold_req", imem_req_out, 0);
            chk("t2_head_seq", pc_seq_out, 32'h4);
            finish();
        end
        drv_stall = 0;
        drive();
        chk("t2_d0_seq", pc_seq_out, 32'h4);
        chk("t2_d0_req", imem_req_out, 0);
        finish();
        drive();
        chk("t2_d1_seq", pc_seq_out, 32'h8);
        chk("t2_d1_req", imem_req_out, 1);
        chk("t2_d1_addr", imem_addr_out, 32'h8);
        finish();

        // redirect while waiting on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset(2);
        drive(); chk("t3_req0", imem_addr_out, 32'h0); finish();
        drv_redir = 1; drv_rpc = 32'h0000_1003;
        drive(); chk("t3_wait_req", imem_req_out, 0); finish();
        drv_redir = 0;
        drive(); chk("t3_flush_valid", valid_out, 0); chk("t3_drop_req", imem_req_out, 0); finish();
        drive(); chk("t3_stale_req", imem_req_out, 0); finish();
        drive();
        chk("t3_new_req", imem_req_out, 1);
        chk("t3_new_addr", imem_addr_out, 32'h0000_1000);
        finish();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive();
            if (valid_out) begin
                seen = 1;
                chk("t3_first_seq", pc_seq_out, 32'h0000_1004);
                chk("t3_first_instr", instr_out, mem_data(32'h0000_1000));
            end
            finish();
        end
        chk("t3_valid_seen", seen, 1);

        // redirect in the same cycle as the response
        lat_min = 1; lat_max = 1;
        do_reset(2);
        cycle();
        drv_redir = 1; drv_rpc = 32'h0000_0200;
        drive(); chk("t4_resp_req", imem_req_out, 0); finish();
        drv_redir = 0;
        drive();
        chk("t4_valid", valid_out, 0);
        chk("t4_req", imem_req_out, 1);
        chk("t4_addr", imem_addr_out, 32'h0000_0200);
        finish();

        // memory not ready for 4 cycles
        do_reset(2);
        drv_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive();
            chk("t5_hold_req", imem_req_out, 1);
            chk("t5_hold_addr", imem_addr_out, 32'h0);
            finish();
        end
        drv_ready = 1;
        cycle();
        cycle();
        drive(); chk("t5_next_addr", imem_addr_out, 32'h4); finish();

        // address wraparound at the top of the space
        do_reset(2);
        drv_ready = 0; drv_redir = 1; drv_rpc = 32'hFFFF_FFFE;
        cycle();
        drv_ready = 1; drv_redir = 0;
        drive(); chk("t6_addr", imem_addr_out, 32'hFFFF_FFFC); finish();
        cycle();
        drive();
        chk("t6_valid", valid_out, 1);
        chk("t6_seq", pc_seq_out, 32'h0);
        chk("t6_seq2", pc_seq_2_out, 32'h4);
        chk("t6_wrap_addr", imem_addr_out, 32'h0);
        finish();

        // randomized traffic
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            drv_reset = ($urandom_range(0, 299) == 0);
            drv_ready = ($urandom_range(0, 9) < 7);
            drv_stall = ($urandom_range(0, 9) < 3);
            drv_redir = ($urandom_range(0, 19) == 0);
            drv_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            drv_spur  = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
